miner_nonce_checker: RTL and testbench
======================================

Name: miner_nonce_checker

Overview:
- Sits directly downstream of the miner control FSM and the SHA core.
- Owns the 32-bit nonce counter advanced by count_enable.
- Compares each finished hash against the job target and raises send_data when a winning nonce is found, which tells the control FSM to return to idle.
- Holds the winning nonce until the host interface acknowledges it, and flags nonce-space exhaustion.

Parameters:
NONCE_W, 32, nonce counter and result width
HASH_W, 256, hash and target width; must be even (split into two halves for the pipelined compare)

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous reset, active-low
load  in  1  single-cycle pulse; starts a new job
start_nonce  in  NONCE_W  first nonce of the job, sampled on load
target  in  HASH_W  job target, sampled on load into an internal register
count_enable  in  1  advance nonce by 1 (from control FSM)
hash_valid  in  1  single-cycle pulse; hash_in is valid for the current nonce_out
hash_in  in  HASH_W  SHA result, unsigned, MSB-first
nonce_out  out  NONCE_W  nonce currently presented to the SHA core
send_data  out  1  level; a winning nonce is held
result_nonce  out  NONCE_W  winning nonce, valid while send_data=1
result_ack  in  1  consumer has taken result_nonce
exhausted  out  1  sticky; nonce counter wrapped with no hit
busy  out  1  job active (state SEARCH)

Behaviour:
- Reset values:
  - nonce_out=0, result_nonce=0, target register=0.
  - send_data=0, exhausted=0, busy=0.
  - State=IDLE; both compare pipeline valid bits cleared.
- FSM states: IDLE, SEARCH, FOUND, EXHAUSTED.
  - IDLE: load -> SEARCH. All other inputs are ignored, and hash_valid is not accepted into the pipe.
  - SEARCH:
    - Compare-stage-2 hit -> FOUND.
    - count_enable with nonce_out == all-ones -> EXHAUSTED.
    - If both occur in the same cycle, the hit wins.
  - FOUND:
    - result_ack -> IDLE; send_data deasserts the next cycle.
    - load without ack -> SEARCH. This drops the result and clears send_data.
  - EXHAUSTED: load -> SEARCH. exhausted clears on load.
- load (any state):
  - nonce_out <= start_nonce; target register <= target.
  - Compare pipeline is flushed (valid bits cleared).
  - Takes priority over count_enable, hash_valid and result_ack in the same cycle.
- Nonce counter:
  - Increments only in SEARCH when count_enable=1 and load=0.
  - Width-wrapping add: all-ones -> 0, which also sets exhausted.
- Compare pipeline (latency 2):
  - Stage 1, on hash_valid in SEARCH, registers:
    - nonce_out as the tagged nonce;
    - upper-half lt and eq flags;
    - the lower half of hash_in.
  - Stage 2 evaluates hit = upper_lt OR (upper_eq AND lower_lt).
  - The compare is strict less-than: hash == target is not a hit.
  - Timing: hash_valid at cycle N gives send_data=1 and result_nonce valid at N+2.
  - Back-to-back hash_valid is accepted every cycle.
  - Only the first hit is kept. Later hits while in FOUND are discarded.
- Nonce tagging: stage 1 captures nonce_out as it stands in the same cycle as hash_valid. A count_enable in that same cycle affects the next nonce only.
- A hit that resolves after the state has left SEARCH (for example, after a load flush) must never assert send_data.
- Reset mid-operation returns all outputs to their reset values immediately (asynchronous), including during FOUND.

Decomposition:
- Package miner_pkg holds:
  - typedef enum checker_state_t {IDLE, SEARCH, FOUND, EXHAUSTED};
  - localparam NONCE_MAX = all-ones of NONCE_W.
  - The miner MCU state typedef can move here later.
- Sub-module hash_lt_cmp implements the 2-stage pipelined unsigned less-than:
  - Ports: clk, n_rst, flush, in_valid, a, b, tag_in, out_valid, out_lt, tag_out.
  - Top level contains only the FSM, nonce counter and result register.

Test Plan:
- Tie start_nonce=0x00000010, target=0x0000FFFF<<224. Pulse load, then hash_valid with hash_in=0xFFFF...F -> no send_data at N+2; busy=1; nonce_out=0x10.
- From the same job, pulse count_enable, then hash_valid with hash_in=0x00000001<<200 -> send_data=1 exactly 2 cycles later, result_nonce=0x11. Pulse result_ack -> send_data=0 next cycle, state IDLE.
- hash_in equal to target -> no hit (strict less-than). Repeat with hash_in = target-1 (lower-half borrow case) -> hit.
- Tie start_nonce=0xFFFFFFFE. Pulse count_enable twice with no hits -> nonce_out=0, exhausted=1, busy=0. Then pulse load -> exhausted=0.
- Drive load and count_enable in the same cycle with start_nonce=0x100 -> nonce_out=0x100, not 0x101. Pulse hash_valid one cycle before a load whose hash would hit -> no send_data.
- In FOUND, drive n_rst=0 asynchronously mid-cycle -> send_data, result_nonce, nonce_out all 0 immediately. After reset release, the state is IDLE.

Source files
------------

// File: rtl/miner_nonce_checker_pkg.sv
// Shared types and constants for the miner datapath blocks.
// The miner MCU state typedef is expected to move in here as well.
package miner_pkg;

    localparam int MINER_NONCE_W = 32;
    localparam int MINER_HASH_W  = 256;

    localparam logic [MINER_NONCE_W-1:0] NONCE_MAX = {MINER_NONCE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        FOUND,
        EXHAUSTED
    } checker_state_t;

endpackage

// File: rtl/miner_nonce_checker_if.sv
// Job, hash and result signals between the miner control side and the nonce checker.
// The master side drives a job in; the slave side is the checker itself.
interface miner_nonce_checker_if #(
    parameter int NONCE_W = 32,
    parameter int HASH_W  = 256
);
    logic               load;
    logic [NONCE_W-1:0] start_nonce;
    logic [HASH_W-1:0]  target;
    logic               count_enable;
    logic               hash_valid;
    logic [HASH_W-1:0]  hash_in;
    logic [NONCE_W-1:0] nonce_out;
    logic               send_data;
    logic [NONCE_W-1:0] result_nonce;
    logic               result_ack;
    logic               exhausted;
    logic               busy;

    modport master (
        output load, start_nonce, target, count_enable, hash_valid, hash_in, result_ack,
        input  nonce_out, send_data, result_nonce, exhausted, busy
    );

    modport slave (
        input  load, start_nonce, target, count_enable, hash_valid, hash_in, result_ack,
        output nonce_out, send_data, result_nonce, exhausted, busy
    );
endinterface

// File: rtl/miner_nonce_checker_cmp.sv
// Two-stage unsigned a < b compare: stage 1 registers the upper-half flags,
// stage 2 resolves the lower half combinationally so the caller can register the result.
module hash_lt_cmp #(
    parameter int W     = 256,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic             out_lt,
    output logic [TAG_W-1:0] tag_out
);

    localparam int H = W / 2;

    logic             s1_valid;
    logic             s1_upper_lt;
    logic             s1_upper_eq;
    logic [H-1:0]     s1_a_lo;
    logic [TAG_W-1:0] s1_tag;

    // b is the job target register, which only changes on a flush, so its
    // lower half can be used live in stage 2 without being staged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1_valid    <= 1'b0;
            s1_upper_lt <= 1'b0;
            s1_upper_eq <= 1'b0;
            s1_a_lo     <= '0;
            s1_tag      <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_upper_lt <= (a[W-1:H] <  b[W-1:H]);
                s1_upper_eq <= (a[W-1:H] == b[W-1:H]);
                s1_a_lo     <= a[H-1:0];
                s1_tag      <= tag_in;
            end
        end
    end

    assign out_valid = s1_valid;
    assign out_lt    = s1_upper_lt | (s1_upper_eq & (s1_a_lo < b[H-1:0]));
    assign tag_out   = s1_tag;

endmodule

// File: rtl/miner_nonce_checker.sv
// Nonce counter, job FSM and winning-nonce register sitting behind the SHA core.
// A hash presented on hash_valid shows up as send_data two cycles later if it beats the target.
module miner_nonce_checker
    import miner_pkg::*;
#(
    parameter int NONCE_W = MINER_NONCE_W,
    parameter int HASH_W  = MINER_HASH_W
) (
    input logic                  clk,
    input logic                  n_rst,
    miner_nonce_checker_if.slave bus
);

    checker_state_t state;
    checker_state_t next_state;

    logic [NONCE_W-1:0] nonce_q;
    logic [NONCE_W-1:0] result_q;
    logic [HASH_W-1:0]  target_q;

    logic               cmp_valid;
    logic               cmp_lt;
    logic [NONCE_W-1:0] cmp_tag;

    logic accept;
    logic hit;
    logic wrap;

    assign accept = bus.hash_valid && (state == SEARCH) && !bus.load;
    assign hit    = cmp_valid && cmp_lt && (state == SEARCH);
    assign wrap   = bus.count_enable && (state == SEARCH) && (&nonce_q);

    hash_lt_cmp #(
        .W     (HASH_W),
        .TAG_W (NONCE_W)
    ) u_cmp (
        .clk       (clk),
        .n_rst     (n_rst),
        .flush     (bus.load),
        .in_valid  (accept),
        .a         (bus.hash_in),
        .b         (target_q),
        .tag_in    (nonce_q),
        .out_valid (cmp_valid),
        .out_lt    (cmp_lt),
        .tag_out   (cmp_tag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // load restarts the job from any state; a hit outranks a counter wrap.
    always_comb begin
        next_state = state;
        if (bus.load) begin
            next_state = SEARCH;
        end else begin
            case (state)
                IDLE:      next_state = IDLE;
                SEARCH: begin
                    if (hit) begin
                        next_state = FOUND;
                    end else if (wrap) begin
                        next_state = EXHAUSTED;
                    end
                end
                FOUND: begin
                    if (bus.result_ack) begin
                        next_state = IDLE;
                    end
                end
                EXHAUSTED: next_state = EXHAUSTED;
                default:   next_state = IDLE;
            endcase
        end
    end

    // Only hits seen in SEARCH are captured, so the first winner is held until ack or load.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            nonce_q  <= '0;
            result_q <= '0;
            target_q <= '0;
        end else if (bus.load) begin
            nonce_q  <= bus.start_nonce;
            target_q <= bus.target;
        end else begin
            if ((state == SEARCH) && bus.count_enable) begin
                nonce_q <= nonce_q + 1'b1;
            end
            if (hit) begin
                result_q <= cmp_tag;
            end
        end
    end

    assign bus.nonce_out    = nonce_q;
    assign bus.result_nonce = result_q;
    assign bus.send_data    = (state == FOUND);
    assign bus.exhausted    = (state == EXHAUSTED);
    assign bus.busy         = (state == SEARCH);

endmodule

// File: tb/tb_miner_nonce_checker.sv
// Directed self-checking bench for miner_nonce_checker with hand-computed expectations.
module tb_miner_nonce_checker;

    logic clk;
    logic n_rst;
    int   errors;
    int   checks;

    logic [255:0] cur_target;

    miner_nonce_checker_if #(.NONCE_W(32), .HASH_W(256)) bus ();

    miner_nonce_checker #(
        .NONCE_W (32),
        .HASH_W  (256)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of stimulus, lets the edge happen, then returns pulses to zero.
    task automatic applyStimulus(input logic ld, input logic [31:0] sn, input logic ce,
                                 input logic hv, input logic [255:0] hin, input logic ack);
        bus.load         = ld;
        bus.start_nonce  = sn;
        bus.target       = cur_target;
        bus.count_enable = ce;
        bus.hash_valid   = hv;
        bus.hash_in      = hin;
        bus.result_ack   = ack;
        tick();
        bus.load         = 1'b0;
        bus.count_enable = 1'b0;
        bus.hash_valid   = 1'b0;
        bus.result_ack   = 1'b0;
        bus.hash_in      = '0;
    endtask

    initial begin
        logic [255:0] all_ones;
        logic [255:0] tgt_b;

        errors           = 0;
        checks           = 0;
        all_ones         = '1;
        cur_target       = {32'h0000FFFF, 224'h0};
        n_rst            = 1'b0;
        bus.load         = 1'b0;
        bus.start_nonce  = '0;
        bus.target       = '0;
        bus.count_enable = 1'b0;
        bus.hash_valid   = 1'b0;
        bus.hash_in      = '0;
        bus.result_ack   = 1'b0;

        tick();
        tick();
        checkOutput("rst_send",   bus.send_data,    1'b0);
        checkOutput("rst_busy",   bus.busy,         1'b0);
        checkOutput("rst_exh",    bus.exhausted,    1'b0);
        checkOutput("rst_nonce",  bus.nonce_out,    32'h0);
        checkOutput("rst_result", bus.result_nonce, 32'h0);
        n_rst = 1'b1;
        tick();

        // Job at 0x10; an all-ones hash must not win.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("load_busy",  bus.busy,      1'b1);
        checkOutput("load_nonce", bus.nonce_out, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, all_ones, 1'b0);
        tick();
        checkOutput("ones_nohit",  bus.send_data, 1'b0);
        checkOutput("ones_busy",   bus.busy,      1'b1);
        checkOutput("ones_nonce",  bus.nonce_out, 32'h10);

        // Advance to 0x11 and hit; send_data must appear exactly two cycles after hash_valid.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("ce_nonce", bus.nonce_out, 32'h11);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 256'h1 << 200, 1'b0);
        checkOutput("hit_n1_send", bus.send_data, 1'b0);
        tick();
        checkOutput("hit_n2_send",   bus.send_data,    1'b1);
        checkOutput("hit_n2_result", bus.result_nonce, 32'h11);
        checkOutput("hit_n2_busy",   bus.busy,         1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("ack_send", bus.send_data, 1'b0);
        checkOutput("ack_busy", bus.busy,      1'b0);
        // In IDLE a winning hash is ignored.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        checkOutput("idle_ignore", bus.send_data, 1'b0);

        // Strict less-than: equal misses, target-1 wins.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, cur_target, 1'b0);
        tick();
        checkOutput("eq_nohit", bus.send_data, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, cur_target - 256'd1, 1'b0);
        tick();
        checkOutput("tm1_hit",    bus.send_data,    1'b1);
        checkOutput("tm1_result", bus.result_nonce, 32'h20);
        // A second winner while holding is dropped.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, '0, 1'b0);
        tick();
        checkOutput("found_keep", bus.result_nonce, 32'h20);
        checkOutput("found_hold", bus.send_data,    1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b1);

        // Upper halves equal, decision made in the lower half.
        tgt_b      = {32'h0000FFFF, 96'h0, 128'h5};
        cur_target = tgt_b;
        applyStimulus(1'b1, 32'h28, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, {32'h0000FFFF, 96'h0, 128'h6}, 1'b0);
        tick();
        checkOutput("lo_gt_nohit", bus.send_data, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, {32'h0000FFFF, 96'h0, 128'h4}, 1'b0);
        tick();
        checkOutput("lo_lt_hit",    bus.send_data,    1'b1);
        checkOutput("lo_lt_result", bus.result_nonce, 32'h28);
        // load while FOUND drops the result and restarts.
        cur_target = {32'h0000FFFF, 224'h0};
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("found_load_send", bus.send_data, 1'b0);
        checkOutput("found_load_busy", bus.busy,      1'b1);

        // Nonce space runs out.
        applyStimulus(1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("pre_wrap_nonce", bus.nonce_out, 32'hFFFFFFFF);
        checkOutput("pre_wrap_exh",   bus.exhausted, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("wrap_nonce", bus.nonce_out, 32'h0);
        checkOutput("wrap_exh",   bus.exhausted, 1'b1);
        checkOutput("wrap_busy",  bus.busy,      1'b0);
        tick();
        checkOutput("exh_sticky", bus.exhausted, 1'b1);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("exh_clear", bus.exhausted, 1'b0);

        // Hit and wrap in the same cycle: the hit wins.
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, '0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("hw_send",   bus.send_data,    1'b1);
        checkOutput("hw_exh",    bus.exhausted,    1'b0);
        checkOutput("hw_result", bus.result_nonce, 32'hFFFFFFFF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b1);

        // load beats count_enable; a hit in flight is flushed by load.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, '0, 1'b0);
        checkOutput("ld_ce_nonce", bus.nonce_out, 32'h100);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("flush_n2", bus.send_data, 1'b0);
        tick();
        checkOutput("flush_n3", bus.send_data, 1'b0);
        checkOutput("flush_busy", bus.busy,    1'b1);

        // Asynchronous reset in FOUND.
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        checkOutput("pre_rst_send", bus.send_data, 1'b1);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("arst_send",   bus.send_data,    1'b0);
        checkOutput("arst_result", bus.result_nonce, 32'h0);
        checkOutput("arst_nonce",  bus.nonce_out,    32'h0);
        tick();
        n_rst = 1'b1;
        tick();
        checkOutput("post_rst_busy", bus.busy, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, '0, 1'b0);
        tick();
        checkOutput("post_rst_idle", bus.send_data, 1'b0);
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("post_rst_load", bus.nonce_out, 32'h50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
